usb3_ep_ram_reader: RTL and testbench
=====================================

// Module: usb3_ep_ram_reader
// PURPOSE
//  Read-side sequencer for the 1024x32 endpoint RAM: takes a (start address, word count) command,
//  issues one RAM read per clock, absorbs the RAM's fixed 2-clock read latency, and presents the
//  words as a valid/ready stream to the USB3 TX packetizer. Sits in the rd_clk domain only.
// PARAMETERS
//  ADR_W   10   RAM address width; addresses wrap modulo 2**ADR_W
//  LEN_W   11   command length width; holds 0..2**ADR_W words
//  FIFO_D  4    output skid FIFO depth; must be >= 4 for 1 word/clk sustained
// PORTS
//  rd_clk        in   1      single clock
//  rd_rst        in   1      synchronous reset, active-high
//  cmd_valid     in   1      command present
//  cmd_ready     out  1      high only in IDLE
//  cmd_adr       in   ADR_W  first RAM word address
//  cmd_len       in   LEN_W  word count; 0 = empty transfer
//  ram_rd_adr    out  ADR_W  to RAM read address
//  ram_rd_dat_r  in   32     from RAM; valid 2 clocks after ram_rd_adr is sampled
//  src_valid     out  1      stream word valid
//  src_ready     in   1      sink accepts
//  src_data      out  32     stream word
//  src_last      out  1      marks final word of the transfer
//  done          out  1      one-clock pulse: transfer finished
//  busy          out  1      high from cmd accept until done
// BEHAVIOUR
//  Reset: cmd_ready=0 in the reset cycle, then 1; src_valid=0, src_last=0, done=0, busy=0, ram_rd_adr=0,
//   FIFO emptied, in-flight pipe cleared, state=IDLE.
//  States: IDLE -> ISSUE (cmd_valid & cmd_ready & cmd_len!=0); IDLE -> DONE (accept with cmd_len==0);
//   ISSUE -> DRAIN when final read issued; DRAIN -> DONE when last word handshaken; DONE -> IDLE next clk.
//  Issue: in ISSUE, a read is issued when remaining!=0 and (fifo_level + inflight) <= FIFO_D-1.
//   ram_rd_adr=adr; adr<=adr+1 (wraps 1023->0); remaining decrements.
//  Latency tracking: 2-stage valid shift register; a word issued at clk t is written to FIFO at t+2.
//   The stage tagged last marks the FIFO entry holding src_last=1.
//  Stream: src_valid=!fifo_empty; src_data/src_last driven from FIFO head; pop on src_valid&src_ready.
//   src_data/src_last stable while src_valid & !src_ready. Simultaneous push and pop: level unchanged.
//  Timing: first src_valid exactly 3 clks after the accept edge; with src_ready held 1, one word per clk,
//   no bubbles; N-word transfer: last handshake at accept+N+2, done at accept+N+3.
//  Backpressure: src_ready=0 stalls issue once fifo_level+inflight=FIFO_D; never overflows, never drops.
//  done: 1 clk, in DONE state; busy=0 in IDLE else 1. cmd_len==0: no RAM reads, no src_valid,
//   done at accept+1.
//  cmd_len>1024 is illegal (undefined); exactly 1024 reads every word once, wrapping address.
//  rd_rst mid-transfer: everything returns to reset values next clk; in-flight RAM data ignored.
// CONFIGURATION
//  USB3_EP_RD_ABORT_EN defined: adds input abort (1 bit). abort=1 in ISSUE/DRAIN: stop issuing, flush FIFO
//   and in-flight pipe next clk, src_valid=0, no src_last emitted, go to DONE (done pulses, plus output
//   aborted=1 for that same clk). abort in IDLE/DONE ignored.
//  Undefined: no abort/aborted ports; transfer always runs to completion.
// TESTING
//  T1 reset, cmd adr=0x010 len=4, src_ready=1 -> ram_rd_adr 0x010..0x013 on consecutive clks;
//   data words at accept+3..+6, src_last on 4th, done at accept+7.
//  T2 cmd adr=0x3FE len=4 -> ram_rd_adr 0x3FE,0x3FF,0x000,0x001; data order matches RAM contents.
//  T3 len=16, src_ready random 50% -> all 16 words in order, none lost/duplicated, src_data stable
//   while stalled, inflight+level never > 4.
//  T4 cmd_len=0 -> no ram read change, src_valid never 1, done at accept+1, cmd_ready back at accept+2.
//  T5 rd_rst asserted mid len=8 transfer after 3 words -> outputs at reset values next clk; new cmd len=2
//   then streams exactly 2 words with src_last on 2nd.
//  T6 (USB3_EP_RD_ABORT_EN) abort after 2 words of len=10 -> src_valid=0 next clk, done=aborted=1 once,
//   then IDLE.

Source files
------------

// File: rtl/usb3_ep_ram_reader_if.sv
// Command, RAM read port and output stream of the endpoint RAM reader, bundled as one interface.
// master = the reader itself, slave = its surroundings (command source, RAM, TX packetizer).
interface usb3_ep_ram_reader_if #(
  parameter int ADR_W = 10,
  parameter int LEN_W = 11
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [ADR_W-1:0] cmd_adr;
  logic [LEN_W-1:0] cmd_len;
  logic [ADR_W-1:0] ram_rd_adr;
  logic [31:0]      ram_rd_dat_r;
  logic             src_valid;
  logic             src_ready;
  logic [31:0]      src_data;
  logic             src_last;
  logic             done;
  logic             busy;

  modport master (
    input  cmd_valid, cmd_adr, cmd_len, ram_rd_dat_r, src_ready,
    output cmd_ready, ram_rd_adr, src_valid, src_data, src_last, done, busy
  );
  modport slave (
    output cmd_valid, cmd_adr, cmd_len, ram_rd_dat_r, src_ready,
    input  cmd_ready, ram_rd_adr, src_valid, src_data, src_last, done, busy
  );
endinterface

// File: rtl/usb3_ep_ram_reader.sv
// Endpoint RAM read sequencer: one read per clock, 2-clock RAM latency absorbed by a skid FIFO.
// Optional abort input/aborted output enabled by defining USB3_EP_RD_ABORT_EN.
module usb3_ep_ram_reader #(
  parameter int ADR_W  = 10,
  parameter int LEN_W  = 11,
  parameter int FIFO_D = 4
) (
  input  logic rd_clk,
  input  logic rd_rst,
`ifdef USB3_EP_RD_ABORT_EN
  input  logic abort,
  output logic aborted,
`endif
  usb3_ep_ram_reader_if.master bus
);
  localparam int RD_LAT = 2;
  localparam int PW     = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
  localparam int CW     = $clog2(FIFO_D + 1);
  localparam int OCC_W  = CW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  typedef struct packed {
    logic        last;
    logic [31:0] data;
  } ent_t;

  state_t              state, state_nx;
  logic [ADR_W-1:0]    adr;
  logic [LEN_W-1:0]    rem;
  logic [RD_LAT-1:0]   vld_pipe, last_pipe;
  ent_t                fifo [FIFO_D];
  logic [PW-1:0]       wp, rp;
  logic [CW-1:0]       level;
  logic [OCC_W-1:0]    occ;
  logic                cmd_acc, issue, push, pop, flush;
  ent_t                head;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_D - 1)) ? '0 : p + 1'b1;
  endfunction

  assign bus.cmd_ready  = (state == IDLE) && !rd_rst;
  assign cmd_acc        = bus.cmd_valid && bus.cmd_ready;
  assign bus.ram_rd_adr = adr;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = (state == DONE);
  assign head           = fifo[rp];
  assign bus.src_valid  = (level != '0);
  assign bus.src_data   = head.data;
  assign bus.src_last   = bus.src_valid && head.last;
  assign pop            = bus.src_valid && bus.src_ready;
  assign push           = vld_pipe[RD_LAT-1] && !flush;

  // Words already promised to the FIFO count against its depth, so it can never overflow.
  assign occ = OCC_W'(level) + OCC_W'(vld_pipe[0]) + OCC_W'(vld_pipe[1]);

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    flush    = 1'b0;
    case (state)
      IDLE:  if (cmd_acc) state_nx = (bus.cmd_len == '0) ? DONE : ISSUE;
      ISSUE: begin
        issue = (rem != '0) && (occ <= OCC_W'(FIFO_D - 1));
        if (issue && rem == LEN_W'(1)) state_nx = DRAIN;
      end
      DRAIN: if (pop && head.last) state_nx = DONE;
      DONE:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
`ifdef USB3_EP_RD_ABORT_EN
    if (abort && (state == ISSUE || state == DRAIN)) begin
      issue    = 1'b0;
      flush    = 1'b1;
      state_nx = DONE;
    end
`endif
  end

  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state     <= IDLE;
      adr       <= '0;
      rem       <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      wp        <= '0;
      rp        <= '0;
      level     <= '0;
    end else begin
      state <= state_nx;
      if (cmd_acc && bus.cmd_len != '0) begin
        adr <= bus.cmd_adr;
        rem <= bus.cmd_len;
      end else if (issue) begin
        adr <= adr + 1'b1;
        rem <= rem - 1'b1;
      end
      if (flush) begin
        vld_pipe  <= '0;
        last_pipe <= '0;
        wp        <= '0;
        rp        <= '0;
        level     <= '0;
      end else begin
        vld_pipe  <= {vld_pipe[RD_LAT-2:0], issue};
        last_pipe <= {last_pipe[RD_LAT-2:0], issue && rem == LEN_W'(1)};
        if (push) wp <= ptr_inc(wp);
        if (pop)  rp <= ptr_inc(rp);
        level <= level + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage needs no reset: level gates every read of it.
  always_ff @(posedge rd_clk) begin
    if (push) fifo[wp] <= '{last: last_pipe[RD_LAT-1], data: bus.ram_rd_dat_r};
  end

`ifdef USB3_EP_RD_ABORT_EN
  logic abt_q;
  always_ff @(posedge rd_clk) begin
    if (rd_rst) abt_q <= 1'b0;
    else        abt_q <= flush;
  end
  assign aborted = abt_q;
`endif
endmodule

// File: tb/tb_usb3_ep_ram_reader.sv
// Bench for usb3_ep_ram_reader: RAM model, stream-level scoreboard monitor and directed tests.
// Abort test compiled only when USB3_EP_RD_ABORT_EN is defined.
module tb_usb3_ep_ram_reader;
  localparam int ADR_W = 10, LEN_W = 11, FIFO_D = 4;

  logic rd_clk = 1'b0;
  logic rd_rst = 1'b1;
  int   checks = 0, errors = 0;

  usb3_ep_ram_reader_if #(.ADR_W(ADR_W), .LEN_W(LEN_W)) bif ();
`ifdef USB3_EP_RD_ABORT_EN
  logic abort = 1'b0;
  logic aborted;
`endif

  usb3_ep_ram_reader #(.ADR_W(ADR_W), .LEN_W(LEN_W), .FIFO_D(FIFO_D)) dut (
    .rd_clk (rd_clk),
    .rd_rst (rd_rst),
`ifdef USB3_EP_RD_ABORT_EN
    .abort  (abort),
    .aborted(aborted),
`endif
    .bus    (bif)
  );

  always #5 rd_clk = ~rd_clk;

  function automatic logic [31:0] ram_word(input logic [ADR_W-1:0] a);
    return 32'hCAFE0000 + 32'(a);
  endfunction

  // RAM: address registered at one edge, data on the output from the next edge.
  logic [ADR_W-1:0] ra_q;
  always @(posedge rd_clk) begin
    ra_q             <= bif.ram_rd_adr;
    bif.ram_rd_dat_r <= ram_word(ra_q);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  // Stream-level model: expected words per accepted command, done one clock after the last
  // word is taken (or right after accepting an empty command), reads-in-flight never above FIFO_D.
  typedef struct { logic [31:0] d; logic l; } exp_t;
  exp_t             exp_q [$];
  logic             done_due = 1'b0, abt_due = 1'b0, stall = 1'b0, stall_l = 1'b0;
  logic [31:0]      stall_d = '0;
  logic             prev_busy = 1'b0;
  logic [ADR_W-1:0] prev_adr = '0;
  int               issued = 0, popped = 0;

  always @(negedge rd_clk) begin
    logic nd, na, abt_now;
    logic [ADR_W-1:0] dlt;
    exp_t e;
    if (rd_rst) begin
      exp_q.delete();
      done_due = 1'b0; abt_due = 1'b0; stall = 1'b0; prev_busy = 1'b0;
      issued = 0; popped = 0;
    end else begin
      chk("done", bif.done, done_due);
`ifdef USB3_EP_RD_ABORT_EN
      chk("aborted", aborted, abt_due);
      abt_now = abort && bif.busy && !bif.done;
`else
      abt_now = 1'b0;
`endif
      if (prev_busy && bif.busy) begin
        dlt = bif.ram_rd_adr - prev_adr;
        issued += int'(dlt);
      end
      if (bif.busy) chk("occupancy_le_depth", 32'(issued - popped <= FIFO_D), 32'd1);
      if (!bif.src_valid) chk("last_while_idle", bif.src_last, 32'd0);
      if (stall) begin
        chk("stall_valid", bif.src_valid, 32'd1);
        chk("stall_data", bif.src_data, stall_d);
        chk("stall_last", bif.src_last, stall_l);
      end
      nd = 1'b0; na = 1'b0;
      if (abt_now) begin
        exp_q.delete();
        nd = 1'b1; na = 1'b1; issued = 0; popped = 0;
      end else if (bif.src_valid && exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL spurious_word actual=%h expected=no word @%0t", bif.src_data, $time);
      end else if (bif.src_valid && bif.src_ready) begin
        e = exp_q.pop_front();
        chk("src_data", bif.src_data, e.d);
        chk("src_last", bif.src_last, 32'(e.l));
        popped++;
        if (e.l) nd = 1'b1;
      end
      if (bif.cmd_valid && bif.cmd_ready) begin
        issued = 0; popped = 0;
        if (bif.cmd_len == '0) nd = 1'b1;
        else for (int i = 0; i < int'(bif.cmd_len); i++)
          exp_q.push_back('{ram_word(bif.cmd_adr + ADR_W'(i)), i == int'(bif.cmd_len) - 1});
      end
      stall     = bif.src_valid && !bif.src_ready && !abt_now;
      stall_d   = bif.src_data;
      stall_l   = bif.src_last;
      done_due  = nd;
      abt_due   = na;
      prev_busy = bif.busy;
      prev_adr  = bif.ram_rd_adr;
    end
  end

  // Returns one time step after the accept edge; the next negedge is cycle 0.
  task automatic send_cmd(input logic [ADR_W-1:0] a, input logic [LEN_W-1:0] n);
    int w = 0;
    @(posedge rd_clk); #1;
    bif.cmd_valid = 1'b1; bif.cmd_adr = a; bif.cmd_len = n;
    while (!bif.cmd_ready && w < 50) begin @(posedge rd_clk); #1; w++; end
    if (!bif.cmd_ready) chk("cmd_ready_timeout", bif.cmd_ready, 32'd1);
    @(posedge rd_clk); #1;
    bif.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string nm, input int bound);
    int w = 0;
    do begin @(negedge rd_clk); w++; end while (!bif.done && w < bound);
    chk(nm, bif.done, 32'd1);
  endtask

  logic [ADR_W-1:0] t2a [4] = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
  logic [ADR_W-1:0] saved;

  initial begin
    bif.cmd_valid = 1'b0; bif.cmd_adr = '0; bif.cmd_len = '0; bif.src_ready = 1'b1;
    // reset
    @(negedge rd_clk); @(negedge rd_clk);
    chk("rst_cycle_cmd_ready", bif.cmd_ready, 32'd0);
    @(posedge rd_clk); #1 rd_rst = 1'b0;
    @(negedge rd_clk);
    chk("rst_cmd_ready", bif.cmd_ready, 32'd1);
    chk("rst_src_valid", bif.src_valid, 32'd0);
    chk("rst_src_last", bif.src_last, 32'd0);
    chk("rst_busy", bif.busy, 32'd0);
    chk("rst_ram_rd_adr", bif.ram_rd_adr, 32'd0);

    // T1: 4 words from 0x010, sink always ready
    send_cmd(10'h010, 11'd4);
    for (int k = 0; k < 9; k++) begin
      @(negedge rd_clk);
      if (k < 4) chk($sformatf("t1_adr_k%0d", k), bif.ram_rd_adr, 32'h10 + k);
      chk($sformatf("t1_valid_k%0d", k), bif.src_valid, 32'(k >= 3 && k <= 6));
      chk($sformatf("t1_last_k%0d", k), bif.src_last, 32'(k == 6));
      chk($sformatf("t1_done_k%0d", k), bif.done, 32'(k == 7));
      if (k == 3) chk("t1_first_data", bif.src_data, 32'hCAFE0010);
      if (k == 6) chk("t1_last_data", bif.src_data, 32'hCAFE0013);
    end

    // T2: address wrap 0x3FE..0x001
    send_cmd(10'h3FE, 11'd4);
    for (int k = 0; k < 6; k++) begin
      @(negedge rd_clk);
      if (k < 4) chk($sformatf("t2_adr_k%0d", k), bif.ram_rd_adr, 32'(t2a[k]));
      if (k == 3) chk("t2_data0", bif.src_data, 32'hCAFE03FE);
      if (k == 5) chk("t2_data2", bif.src_data, 32'hCAFE0000);
    end
    wait_done("t2_done_timeout", 20);

    // T3: 16 words with random backpressure
    bif.src_ready = 1'b0;
    send_cmd(10'h123, 11'd16);
    for (int w = 0; w < 300; w++) begin
      @(negedge rd_clk);
      if (bif.done) break;
      @(posedge rd_clk); #1 bif.src_ready = 1'($urandom_range(1, 0));
    end
    chk("t3_done_seen", bif.done, 32'd1);
    chk("t3_all_delivered", 32'(exp_q.size()), 32'd0);
    @(posedge rd_clk); #1 bif.src_ready = 1'b1;

    // T4: empty transfer
    @(negedge rd_clk);
    saved = bif.ram_rd_adr;
    chk("t4_adr_before", bif.ram_rd_adr, 32'h133);
    send_cmd(10'h055, 11'd0);
    @(negedge rd_clk);
    chk("t4_done_k0", bif.done, 32'd1);
    chk("t4_busy_k0", bif.busy, 32'd1);
    chk("t4_cmd_ready_k0", bif.cmd_ready, 32'd0);
    chk("t4_valid_k0", bif.src_valid, 32'd0);
    chk("t4_adr_k0", bif.ram_rd_adr, 32'(saved));
    @(negedge rd_clk);
    chk("t4_done_k1", bif.done, 32'd0);
    chk("t4_cmd_ready_k1", bif.cmd_ready, 32'd1);
    chk("t4_busy_k1", bif.busy, 32'd0);
    chk("t4_adr_k1", bif.ram_rd_adr, 32'(saved));

    // T5: reset after 3 of 8 words, then a 2-word transfer
    send_cmd(10'h200, 11'd8);
    repeat (6) @(negedge rd_clk);
    @(posedge rd_clk); #1 rd_rst = 1'b1;
    @(negedge rd_clk);
    chk("t5_rst_cycle_cmd_ready", bif.cmd_ready, 32'd0);
    @(posedge rd_clk); #1 rd_rst = 1'b0;
    @(negedge rd_clk);
    chk("t5_src_valid", bif.src_valid, 32'd0);
    chk("t5_src_last", bif.src_last, 32'd0);
    chk("t5_done", bif.done, 32'd0);
    chk("t5_busy", bif.busy, 32'd0);
    chk("t5_ram_rd_adr", bif.ram_rd_adr, 32'd0);
    chk("t5_cmd_ready", bif.cmd_ready, 32'd1);
    send_cmd(10'h3FF, 11'd2);
    for (int k = 0; k < 7; k++) begin
      @(negedge rd_clk);
      chk($sformatf("t5_valid_k%0d", k), bif.src_valid, 32'(k == 3 || k == 4));
      chk($sformatf("t5_last_k%0d", k), bif.src_last, 32'(k == 4));
      chk($sformatf("t5_done_k%0d", k), bif.done, 32'(k == 5));
      if (k == 3) chk("t5_data0", bif.src_data, 32'hCAFE03FF);
      if (k == 4) chk("t5_data1", bif.src_data, 32'hCAFE0000);
    end

`ifdef USB3_EP_RD_ABORT_EN
    // T6: abort after 2 of 10 words
    send_cmd(10'h040, 11'd10);
    repeat (5) @(negedge rd_clk);
    @(posedge rd_clk); #1 abort = 1'b1; bif.src_ready = 1'b0;
    @(negedge rd_clk);
    @(posedge rd_clk); #1 abort = 1'b0; bif.src_ready = 1'b1;
    @(negedge rd_clk);
    chk("t6_valid", bif.src_valid, 32'd0);
    chk("t6_last", bif.src_last, 32'd0);
    chk("t6_done", bif.done, 32'd1);
    chk("t6_aborted", aborted, 32'd1);
    @(negedge rd_clk);
    chk("t6_done_after", bif.done, 32'd0);
    chk("t6_aborted_after", aborted, 32'd0);
    chk("t6_idle_busy", bif.busy, 32'd0);
    chk("t6_idle_cmd_ready", bif.cmd_ready, 32'd1);
    repeat (4) @(negedge rd_clk);
    chk("t6_no_stray_valid", bif.src_valid, 32'd0);
`endif

    repeat (3) @(negedge rd_clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=still running expected=finished");
    $fatal(1, "watchdog");
  end
endmodule
